rom_download_packer: RTL and testbench
======================================

Name: rom_download_packer

Overview:
- Sits between hps_io's ioctl byte stream and the sdram controller's write port during ROM download (ioctl_index 0).
- Packs sequential bytes into 32-bit little-endian words and buffers them in a 2-entry FIFO.
- Issues SDRAM writes over the req/ack handshake and back-pressures hps_io through ioctl_wait.
- Flushes any partial final word when the download ends, then pulses done.

Parameters:
- SDRAM_ADDR_WIDTH, 23: width of sdram_addr, in 16-bit word units.
- IOCTL_ADDR_WIDTH, 20: byte address width of ioctl_addr.
- PAD_BYTE, 8'h00: value of unwritten byte lanes in a flushed partial word.

Ports:
- clk  in  1  system clock (96 MHz domain).
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  high for the whole ROM download.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  IOCTL_ADDR_WIDTH  byte address.
- ioctl_data  in  8  byte value.
- ioctl_wait  out  1  high = hps_io must not issue ioctl_wr.
- sdram_addr  out  SDRAM_ADDR_WIDTH  16-bit word address of the 32-bit write.
- sdram_data  out  32  write data.
- sdram_we  out  1  write enable; equals sdram_req.
- sdram_req  out  1  request, held until ack.
- sdram_ack  in  1  one-cycle accept pulse from the controller.
- busy  out  1  download or drain in progress.
- done  out  1  one-cycle pulse when the last word is acknowledged.

Behaviour:
- Reset (async assert, sync release) clears:
  - all outputs to 0;
  - the assembly register to {4{PAD_BYTE}} with its byte-valid mask cleared;
  - the FIFO to empty;
  - the state machine to IDLE.
- Assembly register:
  - On ioctl_wr, byte lane ioctl_addr[1:0] is loaded; lane 0 is bits 7:0.
  - The word's byte address is tagged as ioctl_addr[IOCTL_ADDR_WIDTH-1:2].
- Push rules:
  - Writing lane 3 pushes {tag, word} into the FIFO in the same cycle.
  - The assembly register is then reset to pad with an empty mask.
  - If ioctl_wr arrives with a tag different from the current non-empty tag, push the old partial word first (same cycle), then load the new byte into a fresh register.
- FIFO:
  - 2 entries; a push and a pop in the same cycle are both allowed.
  - ioctl_wait = FIFO count >= 1 while the assembly mask is non-empty, or count == 2. This guarantees room for the worst case of 2 pushes from one byte.
  - ioctl_wr while ioctl_wait is high is a protocol violation; it is ignored and not written.
- SDRAM side:
  - When the FIFO is non-empty, drive sdram_req = sdram_we = 1, sdram_addr = {tag, 1'b0} zero-extended, and sdram_data = word.
  - All of these stay stable until the sdram_ack cycle.
  - On ack, pop. If another entry remains, req stays high and addr/data update on the next cycle. Otherwise req drops on the next cycle.
  - Latency: a completed word shows req 1 cycle after the lane-3 ioctl_wr.
- State machine:
  - IDLE: on a rising edge of ioctl_download, go to LOAD and set busy = 1.
  - LOAD: accept bytes. On ioctl_download falling, go to FLUSH.
  - FLUSH: push the assembly register if its mask is non-empty (taking one cycle of waiting if the FIFO is full), then go to DRAIN.
  - DRAIN: when the FIFO is empty and no ack is pending, pulse done, clear busy, and go to IDLE.
- ioctl_download rising while in FLUSH/DRAIN is ignored until IDLE; new bytes are blocked by ioctl_wait = 1 in those states.
- Address arithmetic:
  - The tag is truncated or zero-extended to SDRAM_ADDR_WIDTH-1 bits.
  - When the byte address wraps, the words are written at the wrapped address; no error is raised.
- Reset mid-transfer abandons the pending req immediately (req = 0) and discards all buffered data.

Test Plan:
1. Download bytes 00..07 at addr 0..7, ack 2 cycles after each req:
   - write addr 0, data 32'h03020100;
   - then addr 2, data 32'h07060504;
   - done pulses once; busy falls the same cycle.
2. Download 6 bytes AA..AF at addr 0x10..0x15, then drop ioctl_download:
   - addr 8, data 32'hADACABAA;
   - then addr 10, data 32'h0000AFAE (pad 00).
3. Hold sdram_ack low for 20 cycles during a stream:
   - ioctl_wait rises once the FIFO cannot absorb a worst-case double push;
   - no byte is lost;
   - req/addr/data stay constant throughout.
4. Address jump: bytes at 0x00,0x01 then 0x40:
   - write addr 0, data 32'h0000_b1b0;
   - later a word at addr 0x20 with lane 0 set.
5. Assert reset_n low while req is high with a word buffered:
   - req, ioctl_wait, busy, and done all go 0 asynchronously;
   - after release, no write is issued.
6. Back-to-back acks on consecutive cycles with 2 FIFO entries:
   - req stays high across the boundary;
   - the second addr/data appear exactly one cycle after the first ack.

Source files
------------

// File: rtl/rom_download_packer.sv
// Packs the hps_io ROM download byte stream into 32-bit little-endian words and
// writes them to SDRAM through a 2-entry FIFO over a req/ack handshake.
module rom_download_packer #(
  parameter int         SDRAM_ADDR_WIDTH = 23,
  parameter int         IOCTL_ADDR_WIDTH = 20,
  parameter logic [7:0] PAD_BYTE         = 8'h00
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ioctl_download,
  input  logic                        ioctl_wr,
  input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
  input  logic [7:0]                  ioctl_data,
  output logic                        ioctl_wait,
  output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
  output logic [31:0]                 sdram_data,
  output logic                        sdram_we,
  output logic                        sdram_req,
  input  logic                        sdram_ack,
  output logic                        busy,
  output logic                        done
);

  localparam int          TAG_W    = IOCTL_ADDR_WIDTH - 2;
  localparam int          STAG_W   = SDRAM_ADDR_WIDTH - 1;
  localparam logic [31:0] PAD_WORD = {4{PAD_BYTE}};

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t           state_reg;
  logic             dl_reg;

  logic [31:0]      asm_data_reg, asm_data_next;
  logic [3:0]       asm_mask_reg, asm_mask_next;
  logic [TAG_W-1:0] asm_tag_reg, asm_tag_next;

  logic [31:0]      fifo_data_reg [2];
  logic [TAG_W-1:0] fifo_tag_reg  [2];
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic [1:0]       count_reg;

  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       wr_lane;
  logic             dl_rise;
  logic             fifo_wait;
  logic             accept;
  logic             pop;
  logic             tag_mismatch;
  logic [31:0]      base_data, merged_data;
  logic [3:0]       base_mask, merged_mask;
  logic             push_a;
  logic             push_b;
  logic [1:0]       push_cnt;
  logic             flush_done;
  logic [STAG_W-1:0] head_tag_ext;

  assign wr_tag  = ioctl_addr[IOCTL_ADDR_WIDTH-1:2];
  assign wr_lane = ioctl_addr[1:0];
  assign dl_rise = ioctl_download & ~dl_reg;

  // Room is reserved for the worst case of two pushes caused by a single byte.
  assign fifo_wait  = ((count_reg != 2'd0) && (asm_mask_reg != 4'd0)) || (count_reg == 2'd2);
  assign ioctl_wait = fifo_wait || (state_reg == FLUSH) || (state_reg == DRAIN);

  assign accept = ioctl_wr && !ioctl_wait && ioctl_download &&
                  ((state_reg == LOAD) || ((state_reg == IDLE) && dl_rise));
  assign pop    = sdram_ack && (count_reg != 2'd0);

  assign tag_mismatch = (asm_mask_reg != 4'd0) && (wr_tag != asm_tag_reg);
  assign base_data    = tag_mismatch ? PAD_WORD : asm_data_reg;
  assign base_mask    = tag_mismatch ? 4'd0 : asm_mask_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_data[8*gi +: 8] = (wr_lane == 2'(gi)) ? ioctl_data : base_data[8*gi +: 8];
      assign merged_mask[gi]        = (wr_lane == 2'(gi)) | base_mask[gi];
    end
  endgenerate

  // push_a carries the held partial word, push_b the word completed by this byte.
  always_comb begin
    push_a        = 1'b0;
    push_b        = 1'b0;
    flush_done    = 1'b0;
    asm_data_next = asm_data_reg;
    asm_mask_next = asm_mask_reg;
    asm_tag_next  = asm_tag_reg;
    if (accept) begin
      push_a = tag_mismatch;
      if (wr_lane == 2'd3) begin
        push_b        = 1'b1;
        asm_data_next = PAD_WORD;
        asm_mask_next = 4'd0;
      end else begin
        asm_data_next = merged_data;
        asm_mask_next = merged_mask;
        asm_tag_next  = wr_tag;
      end
    end else if (state_reg == FLUSH) begin
      if (asm_mask_reg == 4'd0) begin
        flush_done = 1'b1;
      end else if ((count_reg != 2'd2) || pop) begin
        push_a        = 1'b1;
        flush_done    = 1'b1;
        asm_data_next = PAD_WORD;
        asm_mask_next = 4'd0;
      end
    end
  end

  assign push_cnt = {1'b0, push_a} + {1'b0, push_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_tag_reg[i]  <= '0;
      end
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      asm_data_reg <= PAD_WORD;
      asm_mask_reg <= 4'd0;
      asm_tag_reg  <= '0;
    end else begin
      if (push_a) begin
        fifo_data_reg[wr_ptr_reg] <= asm_data_reg;
        fifo_tag_reg[wr_ptr_reg]  <= asm_tag_reg;
      end else if (push_b) begin
        fifo_data_reg[wr_ptr_reg] <= merged_data;
        fifo_tag_reg[wr_ptr_reg]  <= wr_tag;
      end
      if (push_a && push_b) begin
        fifo_data_reg[~wr_ptr_reg] <= merged_data;
        fifo_tag_reg[~wr_ptr_reg]  <= wr_tag;
      end
      wr_ptr_reg <= wr_ptr_reg ^ push_cnt[0];
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg    <= count_reg + push_cnt - {1'b0, pop};
      asm_data_reg <= asm_data_next;
      asm_mask_reg <= asm_mask_next;
      asm_tag_reg  <= asm_tag_next;
    end
  end

  generate
    if (STAG_W > TAG_W) begin : g_tag_zext
      assign head_tag_ext = {{(STAG_W-TAG_W){1'b0}}, fifo_tag_reg[rd_ptr_reg]};
    end else begin : g_tag_trunc
      assign head_tag_ext = fifo_tag_reg[rd_ptr_reg][STAG_W-1:0];
    end
  endgenerate

  // Head of the FIFO drives the write port directly so req follows a push by one cycle.
  assign sdram_req  = (count_reg != 2'd0);
  assign sdram_we   = sdram_req;
  assign sdram_addr = sdram_req ? {head_tag_ext, 1'b0} : '0;
  assign sdram_data = sdram_req ? fifo_data_reg[rd_ptr_reg] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      dl_reg    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dl_reg <= ioctl_download;
      done   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (dl_rise) begin
            state_reg <= LOAD;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (!ioctl_download) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_done) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (count_reg == 2'd0) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_download_packer.sv
// Randomised and directed bench for rom_download_packer; expected SDRAM writes
// are derived from the list of accepted bytes by a list-level word-grouping model.
module tb_rom_download_packer;

  localparam int SAW = 23;
  localparam int IAW = 20;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           ioctl_download = 1'b0;
  logic           ioctl_wr = 1'b0;
  logic [IAW-1:0] ioctl_addr = '0;
  logic [7:0]     ioctl_data = '0;
  logic           ioctl_wait;
  logic [SAW-1:0] sdram_addr;
  logic [31:0]    sdram_data;
  logic           sdram_we;
  logic           sdram_req;
  logic           sdram_ack = 1'b0;
  logic           busy;
  logic           done;

  rom_download_packer #(
    .SDRAM_ADDR_WIDTH(SAW),
    .IOCTL_ADDR_WIDTH(IAW),
    .PAD_BYTE(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr),
    .sdram_data(sdram_data),
    .sdram_we(sdram_we),
    .sdram_req(sdram_req),
    .sdram_ack(sdram_ack),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IAW-1:0] a; logic [7:0] d; } byte_t;
  typedef struct { logic [SAW-1:0] a; logic [31:0] d; int cyc; } wr_t;

  byte_t sent_q[$];
  wr_t   got_q[$];
  wr_t   exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bytes are grouped into runs sharing one word address; a run closes after lane 3,
  // when the word address changes, or at the end of the download.
  function automatic void push_exp(input int tag, input logic [31:0] w);
    wr_t e;
    e.a = SAW'(tag * 2);
    e.d = w;
    e.cyc = 0;
    exp_q.push_back(e);
  endfunction

  function automatic void build_expected();
    int          cur_tag;
    int          tag;
    int          lane;
    logic [31:0] word;
    bit          open;
    exp_q.delete();
    open = 0;
    cur_tag = 0;
    word = '0;
    foreach (sent_q[i]) begin
      tag  = int'(sent_q[i].a) / 4;
      lane = int'(sent_q[i].a) % 4;
      if (open && tag != cur_tag) begin
        push_exp(cur_tag, word);
        open = 0;
      end
      if (!open) begin
        word = {4{8'h00}};
        cur_tag = tag;
        open = 1;
      end
      word[8*lane +: 8] = sent_q[i].d;
      if (lane == 3) begin
        push_exp(cur_tag, word);
        open = 0;
      end
    end
    if (open) push_exp(cur_tag, word);
  endfunction

  // Ack responder: acks after a per-request delay, can be held off for a number of cycles.
  int dmin = 0, dmax = 0, hold_cnt = 0, wait_cnt = 0, cur_delay = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        hold_cnt--;
        sdram_ack = 1'b0;
      end else if (sdram_req) begin
        if (wait_cnt >= cur_delay) begin
          sdram_ack = 1'b1;
          wait_cnt = 0;
          cur_delay = $urandom_range(dmax, dmin);
        end else begin
          sdram_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        sdram_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  int             cyc = 0;
  int             done_cnt = 0;
  bit             saw_req = 0;
  bit             prev_req = 0, prev_ack = 0, prev_busy = 0;
  logic [SAW-1:0] prev_addr = '0;
  logic [31:0]    prev_data = '0;

  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (!reset_n) begin
      prev_req = 0;
      prev_ack = 0;
      prev_busy = 0;
    end else begin
      if (sdram_req) begin
        saw_req = 1;
        check_eq("we_eq_req", sdram_we, sdram_req);
      end
      if (prev_req && !prev_ack) begin
        check_eq("req_held", sdram_req, 1'b1);
        check_eq("addr_stable", sdram_addr, prev_addr);
        check_eq("data_stable", sdram_data, prev_data);
      end
      if (sdram_req && sdram_ack) begin
        w.a = sdram_addr;
        w.d = sdram_data;
        w.cyc = cyc;
        got_q.push_back(w);
      end
      if (done) begin
        done_cnt++;
        check_eq("busy_low_at_done", busy, 1'b0);
        check_eq("busy_before_done", prev_busy, 1'b1);
      end
      prev_req  = sdram_req;
      prev_ack  = sdram_ack;
      prev_busy = busy;
      prev_addr = sdram_addr;
      prev_data = sdram_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input int lo, input int hi);
    dmin = lo;
    dmax = hi;
    cur_delay = lo;
    wait_cnt = 0;
  endtask

  task automatic start_dl();
    done_cnt = 0;
    got_q.delete();
    sent_q.delete();
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [IAW-1:0] a, input logic [7:0] d);
    byte_t b;
    int n = 0;
    while (ioctl_wait && n < 300) begin
      tick();
      n++;
    end
    if (ioctl_wait) begin
      check_eq("wait_timeout", ioctl_wait, 1'b0);
      return;
    end
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    b.a = a;
    b.d = d;
    sent_q.push_back(b);
  endtask

  task automatic finish_dl(input string name);
    int n = 0;
    int m;
    ioctl_download = 1'b0;
    while (done_cnt == 0 && n < 1000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check_eq({name, "_done_once"}, done_cnt, 1);
    check_eq({name, "_busy_idle"}, busy, 1'b0);
    build_expected();
    check_eq({name, "_nwrites"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_eq({name, "_addr"}, got_q[i].a, exp_q[i].a);
      check_eq({name, "_data"}, got_q[i].d, exp_q[i].d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [IAW-1:0] a;
    int n;
    int r;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wait", ioctl_wait, 1'b0);
    check_eq("rst_req", sdram_req, 1'b0);
    check_eq("rst_we", sdram_we, 1'b0);
    check_eq("rst_addr", sdram_addr, '0);
    check_eq("rst_data", sdram_data, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1: two full words, ack two cycles after each request
    set_ack(2, 2);
    start_dl();
    check_eq("t1_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(IAW'(i), 8'(i));
    check_eq("t1_req_before_lane3", sdram_req, 1'b0);
    send_byte(IAW'(3), 8'h03);
    check_eq("t1_req_latency", sdram_req, 1'b1);
    check_eq("t1_first_addr", sdram_addr, 23'd0);
    check_eq("t1_first_data", sdram_data, 32'h03020100);
    for (int i = 4; i < 8; i++) send_byte(IAW'(i), 8'(i));
    finish_dl("t1");
    if (got_q.size() >= 2) begin
      check_eq("t1_w1_addr", got_q[1].a, 23'd2);
      check_eq("t1_w1_data", got_q[1].d, 32'h07060504);
    end

    // 2: partial final word is flushed with pad bytes
    set_ack(0, 3);
    start_dl();
    for (int i = 0; i < 6; i++) send_byte(IAW'(32'h10 + i), 8'(8'hAA + i));
    finish_dl("t2");
    if (got_q.size() >= 2) begin
      check_eq("t2_w0_addr", got_q[0].a, 23'd8);
      check_eq("t2_w0_data", got_q[0].d, 32'hADACABAA);
      check_eq("t2_w1_addr", got_q[1].a, 23'd10);
      check_eq("t2_w1_data", got_q[1].d, 32'h0000AFAE);
    end

    // 3: ack held off; wait must rise, an illegal strobe must be ignored
    set_ack(0, 1);
    start_dl();
    hold_cnt = 25;
    for (int i = 0; i < 5; i++) send_byte(IAW'(32'h200 + i), 8'(8'h40 + i));
    check_eq("t3_wait_high", ioctl_wait, 1'b1);
    ioctl_addr = IAW'(32'h206);
    ioctl_data = 8'hEE;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    for (int i = 5; i < 16; i++) send_byte(IAW'(32'h200 + i), 8'(8'h40 + i));
    finish_dl("t3");

    // 4: address jump pushes the held partial word
    set_ack(1, 1);
    start_dl();
    send_byte(IAW'(0), 8'hB0);
    send_byte(IAW'(1), 8'hB1);
    send_byte(IAW'(32'h40), 8'hC0);
    finish_dl("t4");
    if (got_q.size() >= 2) begin
      check_eq("t4_w0_addr", got_q[0].a, 23'd0);
      check_eq("t4_w0_data", got_q[0].d, 32'h0000B1B0);
      check_eq("t4_w1_addr", got_q[1].a, 23'h20);
      check_eq("t4_w1_data", got_q[1].d, 32'h000000C0);
    end

    // 5: reset while a request is pending
    set_ack(0, 0);
    start_dl();
    hold_cnt = 1000;
    for (int i = 0; i < 5; i++) send_byte(IAW'(32'h100 + i), 8'(8'h50 + i));
    check_eq("t5_req_pending", sdram_req, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t5_req", sdram_req, 1'b0);
    check_eq("t5_wait", ioctl_wait, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_done", done, 1'b0);
    ioctl_download = 1'b0;
    hold_cnt = 0;
    tick();
    tick();
    reset_n = 1'b1;
    saw_req = 0;
    got_q.delete();
    repeat (30) tick();
    check_eq("t5_no_req", saw_req, 1'b0);
    check_eq("t5_no_write", got_q.size(), 0);
    check_eq("t5_busy_after", busy, 1'b0);

    // 6: two entries drained by back-to-back acks
    set_ack(0, 0);
    start_dl();
    hold_cnt = 1000;
    for (int i = 0; i < 4; i++) send_byte(IAW'(32'h300 + i), 8'(8'h60 + i));
    send_byte(IAW'(32'h307), 8'h77);
    tick();
    check_eq("t6_fifo_full_wait", ioctl_wait, 1'b1);
    hold_cnt = 0;
    finish_dl("t6");
    if (got_q.size() >= 2) begin
      check_eq("t6_ack_gap", got_q[1].cyc - got_q[0].cyc, 1);
      check_eq("t6_w1_data", got_q[1].d, 32'h77000000);
    end

    // address wrap at the top of the byte address space
    set_ack(0, 2);
    start_dl();
    for (int i = 0; i < 10; i++) send_byte(IAW'(32'hFFFFA + i), 8'(8'h80 + i));
    finish_dl("wrap");
    if (got_q.size() >= 1) check_eq("wrap_last_addr", got_q[got_q.size()-1].a, 23'd0);

    // random streams with occasional jumps and random ack latency
    for (int t = 0; t < 6; t++) begin
      set_ack(0, $urandom_range(4, 0));
      start_dl();
      a = IAW'($urandom);
      n = $urandom_range(40, 8);
      for (int k = 0; k < n; k++) begin
        send_byte(a, 8'($urandom));
        repeat ($urandom_range(2, 0)) tick();
        r = $urandom_range(9, 0);
        if (r == 0) a = IAW'($urandom);
        else if (r == 1) a = a + IAW'(2);
        else a = a + IAW'(1);
      end
      finish_dl("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
